m_imem_loader: RTL and testbench

M_IMEM_LOADER -- requirements
Module: m_imem_loader

---
 rtl/m_imem_loader_pkg.sv | 17 +
 rtl/m_imem_loader_if.sv | 30 +++
 rtl/m_word_pack.sv | 39 +++
 rtl/m_imem_loader.sv | 137 +++++++++++++
 tb/tb_m_imem_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/m_imem_loader_pkg.sv
// Shared loader definitions: FSM state encoding, default depth and timeout, bus widths.
package m_imem_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StDone,
      StErr
   } state_e;

   localparam int unsigned DefaultDepth   = 2048;
   localparam int unsigned DefaultTimeout = 1000000;
   localparam int unsigned AddrW          = 11;
   localparam int unsigned LenW           = 12;

endpackage

// File: rtl/m_imem_loader_if.sv
// Host-side load bus plus instruction-memory write port and status of the loader.
interface m_imem_loader_if;
   import m_imem_loader_pkg::*;

   logic             w_start;
   logic [LenW-1:0]  w_len;
   logic [7:0]       w_byte;
   logic             w_byte_valid;
   logic             r_byte_ready;
   logic             r_we;
   logic [AddrW-1:0] r_waddr;
   logic [31:0]      r_wdata;
   logic             r_cpu_rst;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   // Host drives the load request and byte stream.
   modport master (
      output w_start, w_len, w_byte, w_byte_valid,
      input  r_byte_ready, r_we, r_waddr, r_wdata, r_cpu_rst, r_busy, r_done, r_err
   );

   // Loader consumes bytes and drives memory writes and status.
   modport slave (
      input  w_start, w_len, w_byte, w_byte_valid,
      output r_byte_ready, r_we, r_waddr, r_wdata, r_cpu_rst, r_busy, r_done, r_err
   );

endinterface

// File: rtl/m_word_pack.sv
// Assembles accepted bytes big-endian into 32-bit words and keeps the running XOR checksum.
module m_word_pack (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o,
   output logic [7:0]  csum_o
);

   logic [23:0] shift_q;
   logic [1:0]  cnt_q;
   logic [7:0]  csum_q;

   // The word is complete in the cycle its 4th byte is accepted; the top registers it.
   assign word_o      = {shift_q, byte_i};
   assign word_done_o = accept_i && (cnt_q == 2'd3);
   assign csum_o      = csum_q;

   // Shift in each accepted byte, count bytes within the word, fold into the checksum.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
      end else if (clear_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
         csum_q  <= '0;
      end else if (accept_i) begin
         shift_q <= {shift_q[15:0], byte_i};
         cnt_q   <= cnt_q + 2'd1;
         csum_q  <= csum_q ^ byte_i;
      end
   end

endmodule

// File: rtl/m_imem_loader.sv
// Instruction memory loader: receives a byte stream, writes words, verifies an XOR checksum
// and releases the processor reset only after a good load.
module m_imem_loader
   import m_imem_loader_pkg::*;
#(
   parameter int unsigned P_TIMEOUT = DefaultTimeout,
   parameter int unsigned P_DEPTH   = DefaultDepth
) (
   input logic             w_clk,
   input logic             w_rst_n,
   m_imem_loader_if.slave  bus
);

   localparam int unsigned TimerW = $clog2(P_TIMEOUT) + 1;

   logic [1:0]        rst_sync_q;
   logic              rst_int_n;
   state_e            state_q, state_d;
   logic [LenW-1:0]   len_q;
   logic [LenW-1:0]   word_idx_q;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              clear;
   logic              accept;
   logic              pack_accept;
   logic              word_done;
   logic [31:0]       word;
   logic [7:0]        csum;
   logic              last_word;
   logic              timeout;

   // Assert asynchronously, release two edges after the external reset rises.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   assign accept      = bus.w_byte_valid && bus.r_byte_ready;
   // Only program bytes are packed; the byte received in CHECK is the checksum itself.
   assign pack_accept = accept && (state_q == StLoad);
   assign last_word   = (word_idx_q == len_q - LenW'(1));
   assign timeout     = (timer_q == TimerW'(P_TIMEOUT - 1)) && !accept;

   m_word_pack u_word_pack (
      .clk_i       (w_clk),
      .rst_ni      (rst_int_n),
      .clear_i     (clear),
      .accept_i    (pack_accept),
      .byte_i      (bus.w_byte),
      .word_o      (word),
      .word_done_o (word_done),
      .csum_o      (csum)
   );

   // Next state and idle timer.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      clear   = 1'b0;
      case (state_q)
         StIdle, StDone, StErr: begin
            if (bus.w_start) begin
               clear   = 1'b1;
               timer_d = '0;
               if (bus.w_len == '0) begin
                  state_d = StCheck;
               end else if (32'(bus.w_len) > P_DEPTH) begin
                  state_d = StErr;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            timer_d = accept ? '0 : timer_q + TimerW'(1);
            if (word_done && last_word) begin
               state_d = StCheck;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         StCheck: begin
            timer_d = accept ? '0 : timer_q + TimerW'(1);
            if (accept) begin
               state_d = (bus.w_byte == csum) ? StDone : StErr;
            end else if (timeout) begin
               state_d = StErr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counters and registered outputs derived from the next state.
   always_ff @(posedge w_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q          <= StIdle;
         len_q            <= '0;
         word_idx_q       <= '0;
         timer_q          <= '0;
         bus.r_we         <= 1'b0;
         bus.r_waddr      <= '0;
         bus.r_wdata      <= '0;
         bus.r_byte_ready <= 1'b0;
         bus.r_busy       <= 1'b0;
         bus.r_done       <= 1'b0;
         bus.r_err        <= 1'b0;
         bus.r_cpu_rst    <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         if (clear) begin
            len_q      <= bus.w_len;
            word_idx_q <= '0;
         end else if (word_done) begin
            word_idx_q <= word_idx_q + LenW'(1);
         end
         bus.r_we <= word_done;
         if (word_done) begin
            bus.r_waddr <= word_idx_q[AddrW-1:0];
            bus.r_wdata <= word;
         end else if (clear) begin
            bus.r_waddr <= '0;
         end
         bus.r_byte_ready <= (state_d == StLoad) || (state_d == StCheck);
         bus.r_busy       <= (state_d == StLoad) || (state_d == StCheck);
         bus.r_done       <= (state_d == StDone);
         bus.r_err        <= (state_d == StErr);
         bus.r_cpu_rst    <= (state_d != StDone);
      end
   end

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: table of complete loads plus timeout and reset sequences.
module tb_m_imem_loader;
   import m_imem_loader_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   m_imem_loader_if bus ();

   m_imem_loader #(
      .P_TIMEOUT (16),
      .P_DEPTH   (2048)
   ) dut (
      .w_clk   (clk),
      .w_rst_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [11:0]  len;
      int           nb;    // bytes sent, checksum included
      logic [103:0] b;     // first byte in the top bits
      int           nwr;
      logic [95:0]  w;     // first word in the top bits
      bit           done;
      bit           err;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [10:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   bit          ready_seen;
   vec_t        tv[6];

   always @(posedge clk) cyc <= cyc + 1;

   // Log every write and any cycle the loader offered to take a byte.
   always @(negedge clk) begin
      if (bus.r_we) begin
         wr_addr.push_back(bus.r_waddr);
         wr_data.push_back(bus.r_wdata);
         wr_cyc.push_back(cyc);
      end
      if (bus.r_byte_ready) ready_seen <= 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      ready_seen = 1'b0;
   endtask

   task automatic start_load(input logic [11:0] len);
      bus.w_len   = len;
      bus.w_start = 1'b1;
      @(posedge clk);
      #1;
      bus.w_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      bus.w_byte       = b;
      bus.w_byte_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rdy = bus.r_byte_ready;
         @(posedge clk);
         #1;
         if (rdy) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL byte accept: byte %h never accepted within 40 cycles", b);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && bus.r_busy; i++) begin
         @(posedge clk);
         #1;
      end
      check("wait idle", 32'(bus.r_busy), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.w_start      = 1'b0;
      bus.w_len        = '0;
      bus.w_byte       = '0;
      bus.w_byte_valid = 1'b0;

      // The XOR of 12 34 56 78 9A BC DE F0 is 00, so 00 is the good checksum and 08 is bad.
      tv[0] = '{12'd2, 9, {64'h12345678_9ABCDEF0, 8'h00, 32'h0}, 2,
                {64'h12345678_9ABCDEF0, 32'h0}, 1'b1, 1'b0};
      tv[1] = '{12'd2, 9, {64'h12345678_9ABCDEF0, 8'h08, 32'h0}, 2,
                {64'h12345678_9ABCDEF0, 32'h0}, 1'b0, 1'b1};
      tv[2] = '{12'd0, 1, {8'h00, 96'h0}, 0, 96'h0, 1'b1, 1'b0};
      tv[3] = '{12'd2049, 0, 104'h0, 0, 96'h0, 1'b0, 1'b1};
      tv[4] = '{12'd1, 5, {40'h01020304_04, 64'h0}, 1, {32'h01020304, 64'h0}, 1'b1, 1'b0};
      tv[5] = '{12'd3, 13, 104'h11223344_55667788_99AABBCC_CC, 3,
                96'h11223344_55667788_99AABBCC, 1'b1, 1'b0};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst r_we", 32'(bus.r_we), 32'd0);
      check("rst r_waddr", 32'(bus.r_waddr), 32'd0);
      check("rst r_wdata", bus.r_wdata, 32'd0);
      check("rst r_byte_ready", 32'(bus.r_byte_ready), 32'd0);
      check("rst r_busy", 32'(bus.r_busy), 32'd0);
      check("rst r_done", 32'(bus.r_done), 32'd0);
      check("rst r_err", 32'(bus.r_err), 32'd0);
      check("rst r_cpu_rst", 32'(bus.r_cpu_rst), 32'd1);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Table of complete loads; bytes are streamed back-to-back with valid held high.
      for (int t = 0; t < 6; t++) begin
         clear_log();
         start_load(tv[t].len);
         for (int i = 0; i < tv[t].nb; i++) send_byte(tv[t].b[103-8*i -: 8]);
         bus.w_byte_valid = 1'b0;
         wait_idle();
         repeat (2) @(posedge clk);
         #1;
         check($sformatf("case%0d writes", t), 32'(wr_data.size()), 32'(tv[t].nwr));
         for (int i = 0; i < tv[t].nwr && i < wr_data.size(); i++) begin
            check($sformatf("case%0d addr%0d", t, i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("case%0d data%0d", t, i), wr_data[i], tv[t].w[95-32*i -: 32]);
         end
         check($sformatf("case%0d r_done", t), 32'(bus.r_done), 32'(tv[t].done));
         check($sformatf("case%0d r_err", t), 32'(bus.r_err), 32'(tv[t].err));
         check($sformatf("case%0d r_cpu_rst", t), 32'(bus.r_cpu_rst), 32'(!tv[t].done));
         check($sformatf("case%0d ready seen", t), 32'(ready_seen), 32'(tv[t].nb > 0));
         if (tv[t].nwr == 3 && wr_cyc.size() == 3) begin
            check("stream gap 0-1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
            check("stream gap 1-2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
         end
      end

      // Stall after byte 5: error exactly 16 edges after the last accepted byte.
      clear_log();
      start_load(12'd2);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      send_byte(8'hEE);
      bus.w_byte_valid = 1'b0;
      for (k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.r_err) break;
      end
      check("timeout cycles", 32'(k), 32'd16);
      check("timeout writes", 32'(wr_data.size()), 32'd1);
      if (wr_data.size() > 0) check("timeout data0", wr_data[0], 32'hAABBCCDD);
      check("timeout r_busy", 32'(bus.r_busy), 32'd0);
      check("timeout r_cpu_rst", 32'(bus.r_cpu_rst), 32'd1);

      // Reset after byte 6: immediate reset outputs, no write of the partial word 1.
      clear_log();
      start_load(12'd2);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      send_byte(8'h66);
      #2;
      rst_n = 1'b0;
      bus.w_byte_valid = 1'b0;
      #1;
      check("abort r_we", 32'(bus.r_we), 32'd0);
      check("abort r_busy", 32'(bus.r_busy), 32'd0);
      check("abort r_byte_ready", 32'(bus.r_byte_ready), 32'd0);
      check("abort r_cpu_rst", 32'(bus.r_cpu_rst), 32'd1);
      check("abort r_wdata", bus.r_wdata, 32'd0);
      check("abort r_waddr", 32'(bus.r_waddr), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("abort writes", 32'(wr_data.size()), 32'd1);

      // Release with start already requested: nothing may change on the first edge.
      clear_log();
      @(negedge clk);
      rst_n       = 1'b1;
      bus.w_len   = 12'd1;
      bus.w_start = 1'b1;
      @(posedge clk);
      #1;
      check("sync edge1 r_busy", 32'(bus.r_busy), 32'd0);
      for (int i = 0; i < 5 && !bus.r_busy; i++) begin
         @(posedge clk);
         #1;
      end
      bus.w_start = 1'b0;
      check("post-reset r_busy", 32'(bus.r_busy), 32'd1);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'h04);
      bus.w_byte_valid = 1'b0;
      wait_idle();
      check("reload writes", 32'(wr_data.size()), 32'd1);
      if (wr_data.size() > 0) check("reload data0", wr_data[0], 32'h01020304);
      check("reload r_done", 32'(bus.r_done), 32'd1);
      check("reload r_cpu_rst", 32'(bus.r_cpu_rst), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
